// File: rtl/apes_cnt_collect_pkg.sv
// Shared state encoding and parameter defaults for the APES detector counter block.
package apes_cnt_collect_pkg;

   localparam int NCH_DEF     = 8;
   localparam int CW_DEF      = 16;
   localparam int WIN_CYC_DEF = 50000;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'b00,
      ST_COLLECT = 2'b01,
      ST_DONE    = 2'b10
   } state_t;

endpackage

// File: rtl/apes_pulse_sync.sv
// One-bit 2-flop synchronizer plus history flop; evt_o marks a rising edge.
// Latency 2 cycles from det input to evt_o; no backpressure.
module apes_pulse_sync
   import apes_cnt_collect_pkg::*;
(
   input  logic clk50,
   input  logic rst_n,
   input  logic d_i,
   output logic evt_o
);

   logic s1_q, s2_q, s3_q;

   always_ff @(posedge clk50 or negedge rst_n) begin
      if (!rst_n) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
         s3_q <= 1'b0;
      end else begin
         s1_q <= d_i;
         s2_q <= s1_q;
         s3_q <= s2_q;
      end
   end

   assign evt_o = s2_q & ~s3_q;

endmodule

// File: rtl/apes_cnt_collect.sv
// Counts detector pulses per channel over a fixed window; 3-cycle input latency,
// 1-cycle registered readout; no backpressure, counters saturate with sticky flags.
module apes_cnt_collect
   import apes_cnt_collect_pkg::*;
#(
   parameter int NCH     = NCH_DEF,
   parameter int CW      = CW_DEF,
   parameter int WIN_CYC = WIN_CYC_DEF
) (
   input  logic           clk50,
   input  logic           rst_n,
   input  logic           cnt_start,
   input  logic           cnt_clr,
   input  logic [NCH-1:0] det_in,
   input  logic [2:0]     rd_addr,
   output logic [CW-1:0]  rd_data,
   output logic [NCH-1:0] sat,
   output logic           busy,
   output logic           collect_done
);

   localparam int            TW     = (WIN_CYC > 1) ? $clog2(WIN_CYC) : 1;
   localparam logic [TW-1:0] T_LAST = TW'(WIN_CYC - 1);
   localparam logic [CW-1:0] C_MAX  = '1;

   state_t          state_q, state_d;
   logic [TW-1:0]   timer_q, timer_d;
   logic [NCH-1:0]  evt;
   logic [CW-1:0]   cnt [NCH];
   logic [CW-1:0]   rd_sel;
   logic [CW-1:0]   rd_data_q;
   logic            cnt_en;

   always_ff @(posedge clk50 or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         timer_q <= '0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
      end
   end

   // Dropping cnt_start mid-window aborts with the timer frozen where it stopped.
   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      if (cnt_clr) begin
         state_d = ST_IDLE;
         timer_d = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (cnt_start) begin
                  state_d = ST_COLLECT;
                  timer_d = '0;
               end
            end
            ST_COLLECT: begin
               if (!cnt_start)
                  state_d = ST_IDLE;
               else if (timer_q == T_LAST)
                  state_d = ST_DONE;
               else
                  timer_d = timer_q + 1'b1;
            end
            ST_DONE: state_d = ST_DONE;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      busy         = 1'b0;
      collect_done = 1'b0;
      cnt_en       = 1'b0;
      case (state_q)
         ST_COLLECT: begin
            busy   = 1'b1;
            cnt_en = 1'b1;
         end
         ST_DONE: collect_done = 1'b1;
         default: ;
      endcase
   end

   for (genvar g = 0; g < NCH; g++) begin : g_ch
      logic [CW-1:0] cnt_q;
      logic          sat_q;

      apes_pulse_sync u_sync (
         .clk50 (clk50),
         .rst_n (rst_n),
         .d_i   (det_in[g]),
         .evt_o (evt[g])
      );

      always_ff @(posedge clk50 or negedge rst_n) begin
         if (!rst_n) begin
            cnt_q <= '0;
            sat_q <= 1'b0;
         end else if (cnt_clr) begin
            cnt_q <= '0;
            sat_q <= 1'b0;
         end else if (cnt_en && evt[g]) begin
            if (cnt_q == C_MAX)
               sat_q <= 1'b1;
            else
               cnt_q <= cnt_q + 1'b1;
         end
      end

      assign cnt[g] = cnt_q;
      assign sat[g] = sat_q;
   end

   // Addresses beyond the last channel fall through to zero.
   always_comb begin
      rd_sel = '0;
      for (int i = 0; i < NCH; i++) begin
         if (int'(rd_addr) == i)
            rd_sel = cnt[i];
      end
   end

   always_ff @(posedge clk50 or negedge rst_n) begin
      if (!rst_n)
         rd_data_q <= '0;
      else
         rd_data_q <= rd_sel;
   end

   assign rd_data = rd_data_q;

endmodule

// File: tb/tb_apes_cnt_collect.sv
// Self-checking bench for apes_cnt_collect with NCH=8, CW=4, WIN_CYC=100.
module tb_apes_cnt_collect;

   logic       clk50;
   logic       rst_n;
   logic       cnt_start;
   logic       cnt_clr;
   logic [7:0] det_in;
   logic [2:0] rd_addr;
   logic [3:0] rd_data;
   logic [7:0] sat;
   logic       busy;
   logic       collect_done;

   int         n_chk;
   int         n_fail;
   logic [3:0] exp_cnt [8];
   logic [7:0] exp_sat;
   logic [3:0] sb_q [$];
   logic [3:0] exp_v;
   time        t_entry;
   int         cyc;

   apes_cnt_collect #(.NCH(8), .CW(4), .WIN_CYC(100)) dut (
      .clk50        (clk50),
      .rst_n        (rst_n),
      .cnt_start    (cnt_start),
      .cnt_clr      (cnt_clr),
      .det_in       (det_in),
      .rd_addr      (rd_addr),
      .rd_data      (rd_data),
      .sat          (sat),
      .busy         (busy),
      .collect_done (collect_done)
   );

   initial begin
      clk50 = 1'b0;
      forever #10 clk50 = ~clk50;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic model_clear();
      for (int c = 0; c < 8; c++) exp_cnt[c] = 4'd0;
      exp_sat = 8'h00;
   endtask

   task automatic do_clear();
      @(negedge clk50);
      cnt_clr = 1'b1;
      @(negedge clk50);
      cnt_clr = 1'b0;
      model_clear();
   endtask

   task automatic start_collect();
      @(negedge clk50);
      cnt_start = 1'b1;
      @(negedge clk50);
      t_entry = $time;
   endtask

   task automatic pulse(input logic [7:0] mask, input bit counted);
      det_in = mask;
      repeat (2) @(negedge clk50);
      det_in = 8'h00;
      repeat (2) @(negedge clk50);
      if (counted) begin
         for (int c = 0; c < 8; c++) begin
            if (mask[c]) begin
               if (exp_cnt[c] == 4'hF) exp_sat[c] = 1'b1;
               else exp_cnt[c] = exp_cnt[c] + 4'd1;
            end
         end
      end
   endtask

   task automatic wait_done(output int cycles);
      int n = 0;
      while (!collect_done && n < 300) begin
         @(negedge clk50);
         n++;
      end
      cycles = collect_done ? int'(($time - t_entry) / 20) : -1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; cnt_start = 1'b0; cnt_clr = 1'b0; det_in = 8'h00; rd_addr = 3'd0;
      model_clear();
      repeat (3) @(negedge clk50);
      n_chk++;
      if ({rd_data, sat, busy, collect_done} !== 14'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: rd_data=%0d sat=%h busy=%b done=%b, all must be 0", rd_data, sat, busy, collect_done);
      end
      rst_n = 1'b1;
      repeat (2) @(negedge clk50);
      for (int a = 0; a < 8; a++) begin
         rd_addr = 3'(a); sb_q.push_back(exp_cnt[a]);
         @(negedge clk50);
         exp_v = sb_q.pop_front(); n_chk++;
         if (rd_data !== exp_v) begin
            n_fail++; $display("FAIL reset_rd ch%0d: rd_data=%0d expected=%0d", a, rd_data, exp_v);
         end
      end
   endtask

   task automatic test_basic();
      do_clear();
      start_collect();
      n_chk++;
      if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy: busy=%b expected=1", busy); end
      for (int i = 0; i < 10; i++) pulse((i < 3) ? 8'h21 : 8'h01, 1'b1);
      wait_done(cyc);
      n_chk++;
      if (cyc !== 100) begin n_fail++; $display("FAIL basic_window: done after %0d cycles expected=100", cyc); end
      n_chk++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_done: busy=%b expected=0", busy); end
      pulse(8'h02, 1'b0);
      cnt_start = 1'b0;
      repeat (3) @(negedge clk50);
      n_chk++;
      if (collect_done !== 1'b1) begin n_fail++; $display("FAIL basic_done_hold: done=%b expected=1", collect_done); end
      for (int a = 0; a < 8; a++) begin
         rd_addr = 3'(a); sb_q.push_back(exp_cnt[a]);
         @(negedge clk50);
         exp_v = sb_q.pop_front(); n_chk++;
         if (rd_data !== exp_v) begin
            n_fail++; $display("FAIL basic_rd ch%0d: rd_data=%0d expected=%0d", a, rd_data, exp_v);
         end
      end
      n_chk++;
      if (sat !== 8'h00) begin n_fail++; $display("FAIL basic_sat: sat=%h expected=00", sat); end
      cnt_clr = 1'b1;
      @(negedge clk50);
      cnt_clr = 1'b0;
      model_clear();
      n_chk++;
      if ({busy, collect_done} !== 2'b00) begin
         n_fail++; $display("FAIL basic_clr_done: busy=%b done=%b expected 0 0", busy, collect_done);
      end
   endtask

   task automatic test_simultaneous();
      do_clear();
      pulse(8'hFF, 1'b0);
      start_collect();
      for (int i = 0; i < 5; i++) pulse(8'hFF, 1'b1);
      cnt_start = 1'b1;
      wait_done(cyc);
      n_chk++;
      if (cyc !== 100) begin n_fail++; $display("FAIL simul_window: done after %0d cycles expected=100", cyc); end
      cnt_start = 1'b0;
      for (int a = 0; a < 8; a++) begin
         rd_addr = 3'(a); sb_q.push_back(exp_cnt[a]);
         @(negedge clk50);
         exp_v = sb_q.pop_front(); n_chk++;
         if (rd_data !== exp_v) begin
            n_fail++; $display("FAIL simul_rd ch%0d: rd_data=%0d expected=%0d", a, rd_data, exp_v);
         end
      end
   endtask

   task automatic test_saturation();
      do_clear();
      start_collect();
      for (int i = 0; i < 20; i++) pulse(8'h04, 1'b1);
      wait_done(cyc);
      cnt_start = 1'b0;
      n_chk++;
      if (sat !== exp_sat) begin n_fail++; $display("FAIL sat_flags: sat=%h expected=%h", sat, exp_sat); end
      for (int a = 0; a < 8; a++) begin
         rd_addr = 3'(a); sb_q.push_back(exp_cnt[a]);
         @(negedge clk50);
         exp_v = sb_q.pop_front(); n_chk++;
         if (rd_data !== exp_v) begin
            n_fail++; $display("FAIL sat_rd ch%0d: rd_data=%0d expected=%0d", a, rd_data, exp_v);
         end
      end
      do_clear();
      n_chk++;
      if (sat !== 8'h00) begin n_fail++; $display("FAIL sat_clr: sat=%h expected=00", sat); end
      rd_addr = 3'd2; sb_q.push_back(exp_cnt[2]);
      @(negedge clk50);
      exp_v = sb_q.pop_front(); n_chk++;
      if (rd_data !== exp_v) begin n_fail++; $display("FAIL sat_clr_rd: rd_data=%0d expected=%0d", rd_data, exp_v); end
   endtask

   task automatic test_abort();
      int elapsed;
      do_clear();
      start_collect();
      for (int i = 0; i < 3; i++) pulse(8'h80, 1'b1);
      elapsed = int'(($time - t_entry) / 20);
      repeat (40 - elapsed) @(negedge clk50);
      cnt_start = 1'b0;
      @(negedge clk50);
      n_chk++;
      if ({busy, collect_done} !== 2'b00) begin
         n_fail++; $display("FAIL abort_state: busy=%b done=%b expected 0 0", busy, collect_done);
      end
      repeat (80) @(negedge clk50);
      n_chk++;
      if (collect_done !== 1'b0) begin n_fail++; $display("FAIL abort_no_done: done=%b expected=0", collect_done); end
      for (int a = 0; a < 8; a++) begin
         rd_addr = 3'(a); sb_q.push_back(exp_cnt[a]);
         @(negedge clk50);
         exp_v = sb_q.pop_front(); n_chk++;
         if (rd_data !== exp_v) begin
            n_fail++; $display("FAIL abort_rd ch%0d: rd_data=%0d expected=%0d", a, rd_data, exp_v);
         end
      end
   endtask

   task automatic test_clr_priority();
      do_clear();
      @(negedge clk50);
      cnt_start = 1'b1;
      cnt_clr   = 1'b1;
      pulse(8'h01, 1'b0);
      n_chk++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL clrpri_busy: busy=%b expected=0", busy); end
      cnt_start = 1'b0;
      cnt_clr   = 1'b0;
      rd_addr = 3'd0; sb_q.push_back(exp_cnt[0]);
      @(negedge clk50);
      exp_v = sb_q.pop_front(); n_chk++;
      if (rd_data !== exp_v) begin n_fail++; $display("FAIL clrpri_rd: rd_data=%0d expected=%0d", rd_data, exp_v); end
   endtask

   task automatic test_reset_mid();
      int elapsed;
      do_clear();
      start_collect();
      for (int i = 0; i < 4; i++) pulse(8'h02, 1'b1);
      rd_addr = 3'd1; sb_q.push_back(exp_cnt[1]);
      @(negedge clk50);
      exp_v = sb_q.pop_front(); n_chk++;
      if (rd_data !== exp_v) begin n_fail++; $display("FAIL rstmid_pre_rd: rd_data=%0d expected=%0d", rd_data, exp_v); end
      elapsed = int'(($time - t_entry) / 20);
      repeat (50 - elapsed) @(negedge clk50);
      #3 rst_n = 1'b0;
      cnt_start = 1'b0;
      det_in = 8'h08;
      model_clear();
      #1;
      n_chk++;
      if ({rd_data, sat, busy, collect_done} !== 14'd0) begin
         n_fail++;
         $display("FAIL rstmid_outputs: rd_data=%0d sat=%h busy=%b done=%b, all must be 0", rd_data, sat, busy, collect_done);
      end
      @(negedge clk50);
      rst_n = 1'b1;
      repeat (5) @(negedge clk50);
      start_collect();
      repeat (20) @(negedge clk50);
      det_in = 8'h00;
      wait_done(cyc);
      cnt_start = 1'b0;
      n_chk++;
      if (cyc !== 100) begin n_fail++; $display("FAIL rstmid_window: done after %0d cycles expected=100", cyc); end
      for (int a = 0; a < 8; a++) begin
         rd_addr = 3'(a); sb_q.push_back(exp_cnt[a]);
         @(negedge clk50);
         exp_v = sb_q.pop_front(); n_chk++;
         if (rd_data !== exp_v) begin
            n_fail++; $display("FAIL rstmid_rd ch%0d: rd_data=%0d expected=%0d", a, rd_data, exp_v);
         end
      end
   endtask

   initial begin
      n_chk  = 0;
      n_fail = 0;
      test_reset();
      test_basic();
      test_simultaneous();
      test_saturation();
      test_abort();
      test_clr_priority();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
